// File: rtl/mux_nx1_serializer_if.sv
// Lane bus between the striping stage and the serializer; the optional
// start-of-frame flag is present only when MUXL_SOF_EN is defined.
interface mux_nx1_serializer_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8
);
   localparam int LANE_W = $clog2(LANES);

   logic [LANES*DATA_W-1:0] data_in;
   logic [LANES-1:0]        valid_in;
   logic [DATA_W-1:0]       data_out;
   logic                    valid_out;
   logic [LANE_W-1:0]       lane_out;
`ifdef MUXL_SOF_EN
   logic                    sof_out;
`endif

   // master: the side feeding lanes in and consuming the serial stream
   modport master (
      output data_in,
      output valid_in,
      input  data_out,
      input  valid_out,
      input  lane_out
`ifdef MUXL_SOF_EN
      , input sof_out
`endif
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output data_out,
      output valid_out,
      output lane_out
`ifdef MUXL_SOF_EN
      , output sof_out
`endif
   );
endinterface

// File: rtl/mux_nx1_serializer.sv
// LANES-to-1 parallel-to-serial lane multiplexer running on clk_4f, one lane per cycle.
// Optional feature macro: MUXL_SOF_EN adds a registered start-of-frame flag (sof_out).
module mux_nx1_serializer #(
   parameter int LANES        = 4,
   parameter int DATA_W       = 8,
   parameter int MASK_INVALID = 0
) (
   input  logic                 clk_4f,
   input  logic                 reset,
   mux_nx1_serializer_if.slave  bus
);
   localparam int LANE_W = $clog2(LANES);
   // Selector table is padded to a power of two so the phase index never leaves it.
   localparam int SEL_N  = 1 << LANE_W;
   localparam logic [LANE_W-1:0] LAST_PHASE = LANE_W'(LANES - 1);

   logic [LANE_W-1:0]       phase_q, phase_d;
   logic [LANES*DATA_W-1:0] snap_data_q, snap_data_d;
   logic [LANES-1:0]        snap_valid_q, snap_valid_d;
   logic [DATA_W-1:0]       data_out_q, data_out_d;
   logic                    valid_out_q, valid_out_d;
   logic [LANE_W-1:0]       lane_out_q, lane_out_d;

   logic                    frame_start;
   logic [DATA_W-1:0]       lane_data [SEL_N];
   logic [SEL_N-1:0]        lane_valid;
   logic [DATA_W-1:0]       sel_data;
   logic                    sel_valid;

   assign frame_start = (phase_q == '0);

   // Lane 0 is only ever selected on the capture edge, so it comes straight
   // from the inputs; the other lanes come from the frame snapshot.
   generate
      for (genvar gi = 0; gi < SEL_N; gi++) begin : g_sel
         if (gi == 0) begin : g_direct
            assign lane_data[gi]  = bus.data_in[DATA_W-1:0];
            assign lane_valid[gi] = bus.valid_in[0];
         end else if (gi < LANES) begin : g_snap
            assign lane_data[gi]  = snap_data_q[gi*DATA_W +: DATA_W];
            assign lane_valid[gi] = snap_valid_q[gi];
         end else begin : g_unused
            assign lane_data[gi]  = '0;
            assign lane_valid[gi] = 1'b0;
         end
      end
   endgenerate

   assign sel_data  = lane_data[phase_q];
   assign sel_valid = lane_valid[phase_q];

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   always_comb begin
      phase_d = phase_q + LANE_W'(1);
      if (phase_q == LAST_PHASE) begin
         phase_d = '0;
      end
   end

   always_comb begin
      snap_data_d  = snap_data_q;
      snap_valid_d = snap_valid_q;
      if (frame_start) begin
         snap_data_d  = bus.data_in;
         snap_valid_d = bus.valid_in;
      end
   end

   always_comb begin
      data_out_d  = sel_data;
      valid_out_d = sel_valid;
      lane_out_d  = phase_q;
      if ((MASK_INVALID != 0) && !sel_valid) begin
         data_out_d = '0;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         snap_data_q  <= '0;
         snap_valid_q <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         lane_out_q   <= '0;
      end else begin
         snap_data_q  <= snap_data_d;
         snap_valid_q <= snap_valid_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         lane_out_q   <= lane_out_d;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.valid_out = valid_out_q;
   assign bus.lane_out  = lane_out_q;

`ifdef MUXL_SOF_EN
   logic sof_q, sof_d;

   assign sof_d = frame_start;

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         sof_q <= 1'b0;
      end else begin
         sof_q <= sof_d;
      end
   end

   assign bus.sof_out = sof_q;
`endif

   phase_in_range: assert property (@(posedge clk_4f) disable iff (!reset) phase_q <= LAST_PHASE);

endmodule

// File: tb/tb_mux_nx1_serializer.sv
// Scoreboard bench: two serializers (4 lanes unmasked, 5 lanes masked) share stimulus;
// a frame-level reference model fills expectation queues that a monitor drains.
module tb_mux_nx1_serializer;
   typedef struct packed {
      logic [7:0] d;
      logic       v;
      logic [3:0] lane;
      logic       sof;
   } word_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [39:0] din = '0;
   logic [4:0]  vin = '0;

   always #5 clk = ~clk;

   mux_nx1_serializer_if #(.LANES(4), .DATA_W(8)) if_a ();
   mux_nx1_serializer_if #(.LANES(5), .DATA_W(8)) if_b ();

   assign if_a.data_in  = din[31:0];
   assign if_a.valid_in = vin[3:0];
   assign if_b.data_in  = din;
   assign if_b.valid_in = vin;

   mux_nx1_serializer #(.LANES(4), .DATA_W(8), .MASK_INVALID(0)) dut_a (
      .clk_4f (clk),
      .reset  (reset),
      .bus    (if_a)
   );

   mux_nx1_serializer #(.LANES(5), .DATA_W(8), .MASK_INVALID(1)) dut_b (
      .clk_4f (clk),
      .reset  (reset),
      .bus    (if_b)
   );

   word_t pend [2][$];
   word_t expq [2][$];
   int    lanes_of [2] = '{4, 5};
   bit    mask_of  [2] = '{1'b0, 1'b1};
   int    checks = 0;
   int    errors = 0;

   // Reference: a whole frame is queued the moment it is captured; reset throws away
   // whatever is left of the current frame and yields an all-zero word.
   task automatic model_edge(input logic rst_n, input logic [39:0] d, input logic [4:0] v);
      word_t w;
      for (int id = 0; id < 2; id++) begin
         if (!rst_n) begin
            pend[id].delete();
            w = '0;
            expq[id].push_back(w);
         end else begin
            if (pend[id].size() == 0) begin
               for (int i = 0; i < lanes_of[id]; i++) begin
                  w.d    = d[i*8 +: 8];
                  w.v    = v[i];
                  if (mask_of[id] && !v[i]) w.d = 8'h00;
                  w.lane = i[3:0];
                  w.sof  = (i == 0);
                  pend[id].push_back(w);
               end
            end
            expq[id].push_back(pend[id].pop_front());
         end
      end
   endtask

   task automatic cycle(input logic rst_n, input logic [39:0] d, input logic [4:0] v);
      @(negedge clk);
      reset = rst_n;
      din   = d;
      vin   = v;
      model_edge(rst_n, d, v);
   endtask

   task automatic check_word(input int id, input word_t got);
      word_t exp;
      exp = expq[id].pop_front();
`ifndef MUXL_SOF_EN
      exp.sof = 1'b0;
`endif
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL word dut%0d: got data=%h valid=%b lane=%0d sof=%b, required data=%h valid=%b lane=%0d sof=%b",
                  id, got.d, got.v, got.lane, got.sof, exp.d, exp.v, exp.lane, exp.sof);
      end else begin
         $display("txn dut%0d lane=%0d data=%h valid=%b sof=%b", id, got.lane, got.d, got.v, got.sof);
      end
   endtask

   always @(posedge clk) begin
      word_t ga, gb;
      #1;
      ga.d    = if_a.data_out;
      ga.v    = if_a.valid_out;
      ga.lane = 4'(if_a.lane_out);
      gb.d    = if_b.data_out;
      gb.v    = if_b.valid_out;
      gb.lane = 4'(if_b.lane_out);
`ifdef MUXL_SOF_EN
      ga.sof  = if_a.sof_out;
      gb.sof  = if_b.sof_out;
`else
      ga.sof  = 1'b0;
      gb.sof  = 1'b0;
`endif
      if (expq[0].size() > 0) check_word(0, ga);
      if (expq[1].size() > 0) check_word(1, gb);
   end

   function automatic logic [39:0] rnd40();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[39:0];
   endfunction

   localparam logic [39:0] D1 = 40'h55_44_33_22_11;
   localparam logic [39:0] D2 = 40'hEE_DD_CC_BB_AA;

   initial begin
      // Held in reset with random inputs: outputs must stay zero.
      for (int i = 0; i < 5; i++) cycle(1'b0, rnd40(), 5'($urandom()));
      // Steady frames, all lanes valid.
      for (int i = 0; i < 8; i++) cycle(1'b1, D1, 5'b11111);
      // Fresh frame, then change inputs one edge after capture.
      cycle(1'b0, D1, 5'b11111);
      cycle(1'b1, D1, 5'b11111);
      for (int i = 0; i < 11; i++) cycle(1'b1, D2, 5'b11111);
      // Sparse valid pattern: masked lanes read as zero on the masking instance.
      cycle(1'b0, D1, 5'b00101);
      for (int i = 0; i < 10; i++) cycle(1'b1, D1, 5'b00101);
      // Reset right after lane 1 is emitted.
      cycle(1'b0, D1, 5'b11111);
      cycle(1'b1, D1, 5'b11111);
      cycle(1'b1, D1, 5'b11111);
      cycle(1'b0, D1, 5'b11111);
      for (int i = 0; i < 6; i++) cycle(1'b1, D2, 5'b11111);
      // No valid lanes at all.
      for (int i = 0; i < 10; i++) cycle(1'b1, D1, 5'b00000);
      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, rnd40(), 5'($urandom()));
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (expq[0].size() != 0 || expq[1].size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d words unchecked, required 0/0", expq[0].size(), expq[1].size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux_nx1_serializer.md
Name: mux_nx1_serializer

Overview:
- Parametrised parallel-to-serial lane multiplexer for the MUXL2 path. Generalises the fixed 2-lane, 8-bit mux to LANES lanes of DATA_W bits.
- Runs entirely on clk_4f. An internal phase counter replaces the divided clock, so no slower clock is needed.
- Snapshots all lanes once per frame and emits one lane per clk_4f cycle, lane 0 first. Each output word carries its valid bit and its lane index.
- Sits between the lane-striping stage and the serial output conditioning.

Parameters:
- LANES, 4, number of parallel input lanes; legal values 2..16.
- DATA_W, 8, data bits per lane.
- MASK_INVALID, 0, when 1 data_out is forced to 0 for any lane whose valid bit is 0.
- Derived localparam LANE_W = $clog2(LANES).

Ports:
- clk_4f  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset sampled on posedge clk_4f.
- data_in  input  LANES*DATA_W  flat lane bus; lane i occupies bits [i*DATA_W +: DATA_W], lane 0 in the LSBs.
- valid_in  input  LANES  valid bit per lane; bit i belongs to lane i.
- data_out  output  DATA_W  serialised data, registered.
- valid_out  output  1  valid of the lane currently on data_out, registered.
- lane_out  output  LANE_W  index of the lane currently on data_out, registered.

Behaviour:
- Reset is synchronous and active-low. On any posedge with reset==0:
  - phase <= 0.
  - snapshot registers <= 0.
  - data_out, valid_out and lane_out <= 0.
- No reset synchroniser stage; reset acts on the same edge it is sampled.
- Phase counter:
  - Width LANE_W; counts 0..LANES-1 and wraps to 0.
  - Advances on every posedge with reset==1.
  - Also wraps correctly when LANES is not a power of two.
- Frame start (posedge with reset==1 and phase==0):
  - snapshot_data <= data_in and snapshot_valid <= valid_in.
  - Outputs take lane 0 directly from the inputs, not the snapshot: data_out <= data_in lane 0, valid_out <= valid_in[0], lane_out <= 0.
- Remaining frame (posedge with reset==1 and phase==k, k>0):
  - data_out <= snapshot_data lane k.
  - valid_out <= snapshot_valid[k].
  - lane_out <= k.
- Input sampling: inputs are sampled only at phase-0 edges. Changes between frame starts are ignored.
- Latency: lane i of a frame appears on the outputs i+1 edges after... more precisely, it is visible after edge E0+i, where E0 is the capture edge. Throughput is one frame per LANES cycles.
- First frame after reset release captures at the first edge where reset==1.
- MASK_INVALID=1: whenever the selected valid bit is 0, data_out <= 0. valid_out and lane_out behave as normal.
- MASK_INVALID=0: data passes through unmodified regardless of valid.
- Reset asserted mid-frame:
  - The remaining lanes of that frame are discarded.
  - Outputs are 0 from the next edge.
  - After release, a fresh frame starts at lane 0.
- All valid_in bits at 0: the frame is still emitted, with valid_out=0 for all LANES cycles.
- No backpressure; the output is free-running.

Optional Feature:
- Macro: MUXL_SOF_EN.
- Defined:
  - Adds output port sof_out (1 bit, registered).
  - sof_out is 1 exactly on the cycles where lane_out==0 carries a newly captured frame; 0 otherwise.
  - sof_out resets to 0.
- Undefined: the sof_out port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset held low 5 cycles with random inputs -> data_out=0, valid_out=0, lane_out=0 on every cycle.
- LANES=4, DATA_W=8, data_in=0x44332211, valid_in=4'b1111, reset released -> at edges E0..E3: data_out=0x11,0x22,0x33,0x44; lane_out=0,1,2,3; valid_out=1; then wraps and repeats.
- Same setup, but data_in changed to 0xDDCCBBAA at edge E0+1 -> lanes 1..3 still output 0x22,0x33,0x44; next frame outputs 0xAA,0xBB,0xCC,0xDD.
- MASK_INVALID=1, data_in=0x44332211, valid_in=4'b0101 -> data_out=0x11,0x00,0x33,0x00; valid_out=1,0,1,0.
- Reset pulled low for 1 cycle after lane 1 is emitted -> next output is 0, lanes 2 and 3 are never emitted; after release, the frame restarts at lane_out=0.
- With MUXL_SOF_EN defined, LANES=3 -> sof_out=1,0,0,1,0,0..., aligned with lane_out=0,1,2,0,1,2; with the macro undefined, the module compiles without the sof_out port.
